// File: rtl/rv_pkg.sv
// rv_pkg: shared decode types; instruction format codes and default XLEN
package rv_pkg;
    typedef logic [2:0] fmt_t;
    localparam fmt_t FMT_I = 3'd0;
    localparam fmt_t FMT_S = 3'd1;
    localparam fmt_t FMT_B = 3'd2;
    localparam fmt_t FMT_U = 3'd3;
    localparam fmt_t FMT_J = 3'd4;
    localparam fmt_t FMT_Z = 3'd5;
    localparam int XLEN_DEFAULT = 32;
endpackage

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: instruction-in / immediate-out valid-ready channels.
//   in_*  : valid, ready, instr[31:0], fmt, tag[TAG_W-1:0]
//   out_* : valid, ready, imm[XLEN-1:0], tag[TAG_W-1:0], err
//   master = producer/consumer side, slave = immediate generator side
interface imm_gen_pipe_if
    import rv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    fmt_t             in_fmt;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;
    modport master (
        output in_valid, in_instr, in_fmt, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_err
    );
    modport slave (
        input  in_valid, in_instr, in_fmt, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_err
    );
endinterface

// File: rtl/imm_extract.sv
// imm_extract: combinational RISC-V immediate extraction and extension.
//   instr[31:0], fmt -> imm[XLEN-1:0], err (fmt 6/7 gives imm=0, err=1)
module imm_extract
    import rv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]     instr,
    input  fmt_t            fmt,
    output logic [XLEN-1:0] imm,
    output logic            err
);
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_extract: XLEN must be 32 or 64");
    end
    // opcode bits never feed an immediate
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];
    // each field is built with instr[31] replicated up to XLEN so no
    // zero-width replication appears at XLEN=32
    always_comb begin
        err = fmt[2] & fmt[1];
        imm = fmt == FMT_I ? {{(XLEN-11){instr[31]}}, instr[30:20]} :
              fmt == FMT_S ? {{(XLEN-11){instr[31]}}, instr[30:25], instr[11:7]} :
              fmt == FMT_B ? {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
              fmt == FMT_U ? {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0} :
              fmt == FMT_J ? {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0} :
              fmt == FMT_Z ? {{(XLEN-5){1'b0}}, instr[19:15]} :
                             '0;
    end
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with one-entry skid buffer.
//   clk, rst (sync, active high), flush (drops everything in flight)
//   bus : imm_gen_pipe_if.slave, one-cycle latency, full throughput
module imm_gen_pipe
    import rv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int TAG_W = 32
) (
    input logic          clk,
    input logic          rst,
    input logic          flush,
    imm_gen_pipe_if.slave bus
);
    logic [XLEN-1:0]  ext_imm;
    logic             ext_err;
    logic             skid_valid;
    logic [XLEN-1:0]  skid_imm;
    logic [TAG_W-1:0] skid_tag;
    logic             skid_err;
    logic             acc;
    logic             con;
    imm_extract #(.XLEN(XLEN)) u_ext (
        .instr (bus.in_instr),
        .fmt   (bus.in_fmt),
        .imm   (ext_imm),
        .err   (ext_err)
    );
    // ready comes only from registered state, never from out_ready
    assign bus.in_ready = !skid_valid && !rst;
    assign acc = bus.in_valid && bus.in_ready;
    assign con = bus.out_valid && bus.out_ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_imm   <= '0;
            bus.out_tag   <= '0;
            bus.out_err   <= 1'b0;
            skid_valid    <= 1'b0;
            skid_imm      <= '0;
            skid_tag      <= '0;
            skid_err      <= 1'b0;
        end else if (flush) begin
            bus.out_valid <= 1'b0;
            skid_valid    <= 1'b0;
        end else if (skid_valid) begin
            // in_ready is low here, so only a drain can happen
            if (con) begin
                bus.out_imm <= skid_imm;
                bus.out_tag <= skid_tag;
                bus.out_err <= skid_err;
                skid_valid  <= 1'b0;
            end
        end else if (acc) begin
            if (!bus.out_valid || con) begin
                bus.out_valid <= 1'b1;
                bus.out_imm   <= ext_imm;
                bus.out_tag   <= bus.in_tag;
                bus.out_err   <= ext_err;
            end else begin
                skid_valid <= 1'b1;
                skid_imm   <= ext_imm;
                skid_tag   <= bus.in_tag;
                skid_err   <= ext_err;
            end
        end else if (con) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed self-checking bench for imm_gen_pipe at XLEN 32 and 64
module tb_imm_gen_pipe;
    import rv_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int n_chk = 0;
    int n_pass = 0;
    always #5 clk = ~clk;
    imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) b32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) b64 ();
    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u32 (.clk(clk), .rst(rst), .flush(flush), .bus(b32));
    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u64 (.clk(clk), .rst(rst), .flush(flush), .bus(b64));
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic drive32(input logic v, input logic [2:0] f, input logic [31:0] ins, input logic [31:0] tg);
        b32.in_valid = v;
        b32.in_fmt   = f;
        b32.in_instr = ins;
        b32.in_tag   = tg;
    endtask
    task automatic drive64(input logic v, input logic [2:0] f, input logic [31:0] ins, input logic [31:0] tg);
        b64.in_valid = v;
        b64.in_fmt   = f;
        b64.in_instr = ins;
        b64.in_tag   = tg;
    endtask
    logic [2:0]  v_fmt [5] = '{FMT_I, FMT_S, FMT_B, FMT_U, FMT_J};
    logic [31:0] v_ins [5] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000EE3, 32'h123450B7, 32'hFFDFF06F};
    logic [31:0] v_exp [5] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h12345000, 32'hFFFFFFFC};
    logic [2:0]  w_fmt [3] = '{FMT_I, FMT_U, FMT_Z};
    logic [31:0] w_ins [3] = '{32'hFFF00093, 32'h800000B7, 32'h340FD073};
    logic [63:0] w_exp [3] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000, 64'h000000000000001F};
    initial begin
        logic [31:0] q[$];
        logic [31:0] st_tag;
        logic [31:0] st_imm;
        logic stall;
        logic acc;
        logic con;
        int nxt;
        int cnt;
        int got;
        int cyc;
        drive32(0, 0, 0, 0);
        drive64(0, 0, 0, 0);
        b32.out_ready = 1'b1;
        b64.out_ready = 1'b1;
        step;
        step;
        chk("rst_rdy32", b32.in_ready, 0);
        chk("rst_vld32", b32.out_valid, 0);
        chk("rst_vld64", b64.out_valid, 0);
        rst = 1'b0;
        #1;
        chk("rdy_after_rst", b32.in_ready, 1);
        // XLEN=32 formats, back to back, one-cycle latency
        for (int k = 0; k < 5; k++) begin
            drive32(1, v_fmt[k], v_ins[k], 32'(k + 16));
            step;
            chk("x32_vld", b32.out_valid, 1);
            chk("x32_imm", b32.out_imm, v_exp[k]);
            chk("x32_tag", b32.out_tag, 32'(k + 16));
            chk("x32_err", b32.out_err, 0);
        end
        drive32(0, 0, 0, 0);
        step;
        chk("x32_drain", b32.out_valid, 0);
        // XLEN=64
        for (int k = 0; k < 3; k++) begin
            drive64(1, w_fmt[k], w_ins[k], 32'(k + 32));
            step;
            chk("x64_vld", b64.out_valid, 1);
            chk("x64_imm", b64.out_imm, w_exp[k]);
            chk("x64_tag", b64.out_tag, 32'(k + 32));
        end
        drive64(0, 0, 0, 0);
        step;
        chk("x64_drain", b64.out_valid, 0);
        // invalid format, then a valid one clears err
        drive32(1, 3'd6, 32'hFFFFFFFF, 32'h60);
        step;
        chk("inv_imm", b32.out_imm, 0);
        chk("inv_err", b32.out_err, 1);
        drive32(1, 3'd7, 32'hFFFFFFFF, 32'h61);
        step;
        chk("inv7_err", b32.out_err, 1);
        drive32(1, FMT_I, 32'hFFF00093, 32'h62);
        step;
        chk("val_err", b32.out_err, 0);
        chk("val_imm", b32.out_imm, 32'hFFFFFFFF);
        drive32(0, 0, 0, 0);
        step;
        // backpressure stream, occupancy-count model with FIFO scoreboard
        nxt = 1; cnt = 0; got = 0; cyc = 0; stall = 0; st_tag = 0; st_imm = 0;
        while (got < 6 && cyc < 80) begin
            b32.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            drive32(nxt <= 6, FMT_I, 32'(nxt) << 20, 32'(nxt));
            #1;
            if (stall) begin
                chk("bp_hold_tag", b32.out_tag, st_tag);
                chk("bp_hold_imm", b32.out_imm, st_imm);
            end
            chk("bp_rdy", b32.in_ready, cnt < 2);
            chk("bp_vld", b32.out_valid, cnt > 0);
            acc = b32.in_valid && cnt < 2;
            con = cnt > 0 && b32.out_ready;
            if (con) begin
                chk("bp_tag", b32.out_tag, q[0]);
                chk("bp_imm", b32.out_imm, q[0]);
                void'(q.pop_front());
                got++;
            end
            if (acc) begin
                q.push_back(32'(nxt));
                nxt++;
            end
            stall = cnt > 0 && !b32.out_ready;
            st_tag = b32.out_tag;
            st_imm = b32.out_imm;
            cnt = cnt + int'(acc) - int'(con);
            step;
            cyc++;
        end
        chk("bp_count", 64'(got), 6);
        drive32(0, 0, 0, 0);
        b32.out_ready = 1'b1;
        step;
        chk("bp_empty", b32.out_valid, 0);
        // flush with output and skid full
        b32.out_ready = 1'b0;
        drive32(1, FMT_I, 32'h0A100000, 32'hA1);
        step;
        drive32(1, FMT_I, 32'h0A200000, 32'hA2);
        step;
        chk("fl_skid_full", b32.in_ready, 0);
        flush = 1'b1;
        drive32(1, FMT_I, 32'h0A300000, 32'hA3);
        step;
        flush = 1'b0;
        drive32(0, 0, 0, 0);
        #1;
        chk("fl_vld", b32.out_valid, 0);
        chk("fl_rdy", b32.in_ready, 1);
        b32.out_ready = 1'b1;
        step;
        chk("fl_nothing", b32.out_valid, 0);
        // flush while a handshake completes: input dropped
        b32.out_ready = 1'b0;
        drive32(1, FMT_I, 32'h0B100000, 32'hB1);
        step;
        chk("fl2_tag", b32.out_tag, 32'hB1);
        flush = 1'b1;
        drive32(1, FMT_I, 32'h0B200000, 32'hB2);
        #1;
        chk("fl2_hs", b32.in_ready, 1);
        step;
        flush = 1'b0;
        drive32(0, 0, 0, 0);
        #1;
        chk("fl2_vld", b32.out_valid, 0);
        b32.out_ready = 1'b1;
        step;
        chk("fl2_nothing", b32.out_valid, 0);
        // reset mid-stream
        b32.out_ready = 1'b0;
        drive32(1, FMT_I, 32'hFFF00093, 32'hC1);
        step;
        drive32(1, FMT_I, 32'hFFF00093, 32'hC2);
        step;
        rst = 1'b1;
        drive32(1, FMT_I, 32'hFFF00093, 32'hC3);
        #1;
        chk("mrst_rdy", b32.in_ready, 0);
        step;
        rst = 1'b0;
        drive32(0, 0, 0, 0);
        #1;
        chk("mrst_vld", b32.out_valid, 0);
        chk("mrst_imm", b32.out_imm, 0);
        chk("mrst_tag", b32.out_tag, 0);
        chk("mrst_err", b32.out_err, 0);
        chk("mrst_rdy_after", b32.in_ready, 1);
        b32.out_ready = 1'b1;
        step;
        chk("mrst_nothing", b32.out_valid, 0);
        drive32(1, FMT_I, 32'hFFF00093, 32'h77);
        step;
        chk("post_vld", b32.out_valid, 1);
        chk("post_imm", b32.out_imm, 32'hFFFFFFFF);
        chk("post_tag", b32.out_tag, 32'h77);
        drive32(0, 0, 0, 0);
        step;
        chk("post_drain", b32.out_valid, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Pipelined, parametrised immediate generator for the decode stage. Successor to the combinational sign-extender.
- Accepts a 32-bit instruction, a format code and a sideband tag (PC) over a valid/ready handshake.
- Produces the XLEN-wide extended immediate one cycle later, with full-throughput backpressure via a one-entry skid buffer.
- Adds the CSR zero-extended immediate format, an invalid-format error flag, and a pipeline flush.

Parameters:
- XLEN, 32, immediate/output width; legal values 32 or 64. Any other value is a synthesis-time error.
- TAG_W, 32, width of the sideband tag carried alongside the instruction (normally the PC).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline flush (branch/trap redirect).
- in_valid  in  1  input instruction valid.
- in_ready  out  1  block can accept this cycle.
- in_instr  in  32  raw instruction word.
- in_fmt  in  3  format: 0=I 1=S 2=B 3=U 4=J 5=Z(CSR uimm) 6,7=invalid.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  output immediate valid.
- out_ready  in  1  consumer accepts this cycle.
- out_imm  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag matching out_imm.
- out_err  out  1  format code was 6 or 7.

Behaviour:
- Immediate formation: combinational from in_instr/in_fmt, then registered. Sign bit is in_instr[31], replicated to XLEN.
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}, sign-extended to XLEN.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - Z: zero-extend instr[19:15].
  - Invalid (6, 7): imm = 0 and err = 1. err = 0 for all other formats.
- Storage: an output register (out_*) and a skid register (skid_valid, skid_imm, skid_tag, skid_err).
- in_ready = !skid_valid && !rst. It depends only on registered state, never combinationally on out_ready.
- An input is accepted when in_valid && in_ready. The output is consumed when out_valid && out_ready.
- Latency: an input accepted in cycle N appears on out_* in cycle N+1 when the output register is empty or being consumed. Sustained throughput is 1 per cycle.
- Accept with the output register full and not consumed: the entry goes into skid; in_ready drops next cycle.
- Consume with skid_valid = 1: the skid entry moves to the output register and skid_valid clears. Ordering is strictly FIFO.
- Accept and consume in the same cycle with skid empty: the new entry overwrites the output register directly.
- out_* stay stable while out_valid && !out_ready.
- flush: next cycle out_valid = 0 and skid_valid = 0. An input presented in the flush cycle is dropped even if the handshake completes. in_ready is 1 the cycle after flush.
- Reset: priority rst > flush > handshake. On the cycle after rst, all of the following are 0: out_valid, out_imm, out_tag, out_err, skid_valid, skid data. in_ready is 0 while rst is high and 1 after.
- Reset asserted mid-stream: all in-flight entries are discarded; nothing is emitted afterwards.
- out_imm, out_tag and out_err are don't-care-free: they hold their last value when out_valid = 0.

Decomposition:
- Shared package rv_pkg holds:
  - the fmt_t typedef (3 bits) with localparams FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_Z;
  - XLEN_DEFAULT = 32.
- Sub-module imm_extract: purely combinational; (instr, fmt) -> (imm[XLEN-1:0], err). It is reused by other decoders.
- imm_gen_pipe contains only the handshake, skid and flush logic.

Test Plan:
- XLEN=32, out_ready=1: I 0xFFF00093 -> 0xFFFFFFFF; S 0xFE112E23 -> 0xFFFFFFFC; U 0x123450B7 -> 0x12345000; J 0xFFDFF06F -> 0xFFFFFFFC. Each appears exactly one cycle after acceptance.
- XLEN=64: I 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF. U 0x800000B7 -> 0xFFFFFFFF80000000. Z fmt 0x340FD073 -> 0x000000000000001F.
- Backpressure: stream tags 1..6 back-to-back while out_ready toggles 1,0,0,1,... Required: no loss or duplication, tags in order, in_ready low only while skid is full, out_* stable while stalled.
- Invalid fmt 6 with instr 0xFFFFFFFF -> out_imm = 0, out_err = 1. The next fmt 0 input gives out_err = 0.
- Flush with out and skid both full and in_valid = 1: next cycle out_valid = 0 and in_ready = 1. The flush-cycle input never appears.
- rst pulsed mid-stream: the cycle after, out_valid = 0 and out_imm = 0. The first post-reset input emerges with the correct value after one cycle.
